// File: rtl/io_uart_responder.sv
// io_uart_responder: target side of the core's IO write/read port.
// Decodes a one-hot word address (io_addr[15:2]) onto three registers:
//   w[0] LED register (6 bits, read back in [5:0])
//   w[1] UART transmit data (push into TX FIFO; reads as 0)
//   w[2] UART status: [9] fifo_full, [10] tx_idle, [11] sticky overflow
//        (write 1 to bit 11 to clear)
// Multiple selected bits write every selected register; reads are ORed.
// Reads are combinational because the core samples data with the address.
//
// Ports:
//   clk       clock
//   resetn    synchronous reset, active-low
//   io_addr   IO byte address
//   io_wdata  IO write data
//   io_wr     one-cycle write strobe
//   io_rdata  combinational read data
//   leds      LED register
//   uart_tx   8N1 serial output, idle high, registered
module io_uart_responder #(
   parameter int unsigned CLK_FREQ_HZ = 10000000,
   parameter int unsigned BAUD_RATE   = 1000000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_wdata,
   input  logic        io_wr,
   output logic [31:0] io_rdata,
   output logic [5:0]  leds,
   output logic        uart_tx
);

   localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("io_uart_responder: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("io_uart_responder: FIFO_DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Address decode
   logic w_sel_led, w_sel_data, w_sel_stat;
   assign w_sel_led  = io_addr[2];
   assign w_sel_data = io_addr[3];
   assign w_sel_stat = io_addr[4];

   logic w_unused_bits;
   assign w_unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata[31:12], io_wdata[10:8]};

   // State
   logic [5:0]        r_leds;
   logic              r_ovf;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   state_e            r_state;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              r_tx;

   // Next-state
   state_e            w_state_d;
   logic [BAUD_W-1:0] w_baud_d;
   logic [2:0]        w_bit_d;
   logic [7:0]        w_shift_d;
   logic              w_tx_d;
   logic              w_pop;

   logic w_full, w_empty, w_push, w_ovf_set, w_ovf_clr, w_tx_idle;
   logic [31:0] w_status;

   // Full/empty are taken before any same-cycle push or pop.
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_push    = io_wr & w_sel_data & ~w_full;
   assign w_ovf_set = io_wr & w_sel_data & w_full;
   assign w_ovf_clr = io_wr & w_sel_stat & io_wdata[11];
   assign w_tx_idle = w_empty & (r_state == StIdle);
   assign w_status  = {20'b0, r_ovf, w_tx_idle, w_full, 9'b0};

   // Registers: LED and overflow
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_leds <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (io_wr && w_sel_led) r_leds <= io_wdata[5:0];
         // Set wins over a same-cycle clear.
         r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      end
   end

   // TX FIFO storage (contents need no reset; pointers and count do)
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= io_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // TX FSM state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= StIdle;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_baud  <= w_baud_d;
         r_bit   <= w_bit_d;
         r_shift <= w_shift_d;
         r_tx    <= w_tx_d;
      end
   end

   // TX FSM next-state; w_tx_d is the line level for the cycle after this edge.
   always_comb begin
      w_state_d = r_state;
      w_baud_d  = r_baud;
      w_bit_d   = r_bit;
      w_shift_d = r_shift;
      w_tx_d    = r_tx;
      w_pop     = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_tx_d = 1'b1;
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_shift_d = r_mem[r_rd_ptr];
               w_baud_d  = BAUD_LOAD;
               w_state_d = StStart;
               w_tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (r_baud == '0) begin
               w_state_d = StData;
               w_bit_d   = 3'd0;
               w_baud_d  = BAUD_LOAD;
               w_tx_d    = r_shift[0];
            end else begin
               w_baud_d = r_baud - BAUD_W'(1);
            end
         end
         StData: begin
            if (r_baud == '0) begin
               w_baud_d = BAUD_LOAD;
               if (r_bit == 3'd7) begin
                  w_state_d = StStop;
                  w_tx_d    = 1'b1;
               end else begin
                  w_bit_d   = r_bit + 3'd1;
                  w_shift_d = r_shift >> 1;
                  w_tx_d    = r_shift[1];
               end
            end else begin
               w_baud_d = r_baud - BAUD_W'(1);
            end
         end
         StStop: begin
            if (r_baud == '0) begin
               if (!w_empty) begin
                  // Back-to-back frame: straight into the next start bit.
                  w_pop     = 1'b1;
                  w_shift_d = r_mem[r_rd_ptr];
                  w_baud_d  = BAUD_LOAD;
                  w_state_d = StStart;
                  w_tx_d    = 1'b0;
               end else begin
                  w_state_d = StIdle;
                  w_tx_d    = 1'b1;
               end
            end else begin
               w_baud_d = r_baud - BAUD_W'(1);
            end
         end
         default: begin
            w_state_d = StIdle;
            w_tx_d    = 1'b1;
         end
      endcase
   end

   // Combinational read mux
   always_comb begin
      io_rdata = '0;
      if (w_sel_led)  io_rdata = io_rdata | {26'b0, r_leds};
      if (w_sel_stat) io_rdata = io_rdata | w_status;
   end

   assign leds    = r_leds;
   assign uart_tx = r_tx;

endmodule

// File: tb/tb_io_uart_responder.sv
// Randomized scoreboard bench for io_uart_responder. A transaction-level model
// (byte queue plus "transmitter busy until cycle N") predicts register reads
// and the serial frames; monitors compare DUT outputs against queued
// expectations.
module tb_io_uart_responder;

   localparam int unsigned CLK_HZ = 10_000_000;
   localparam int unsigned BAUD   = 1_000_000;
   localparam int unsigned DEPTH  = 4;
   localparam int          DIV    = CLK_HZ / BAUD;
   localparam int          FRAME  = 10 * DIV;

   localparam logic [31:0] LED_ADDR  = 32'h0040_0004;
   localparam logic [31:0] DATA_ADDR = 32'h0040_0008;
   localparam logic [31:0] STAT_ADDR = 32'h0040_0010;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] io_addr = '0;
   logic [31:0] io_wdata = '0;
   logic        io_wr = 1'b0;
   logic [31:0] io_rdata;
   logic [5:0]  leds;
   logic        uart_tx;

   io_uart_responder #(
      .CLK_FREQ_HZ(CLK_HZ),
      .BAUD_RATE  (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .io_addr (io_addr),
      .io_wdata(io_wdata),
      .io_wr   (io_wr),
      .io_rdata(io_rdata),
      .leds    (leds),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model state
   logic [7:0] m_q[$];
   logic [5:0] m_leds = '0;
   bit         m_ovf = 1'b0;
   int         m_busy_until = 0;

   typedef struct {
      logic [7:0] data;
      int         start;
   } frame_t;
   typedef struct {
      logic [31:0] rdata;
      logic [5:0]  leds;
   } rd_t;

   frame_t exp_q[$];
   rd_t    rd_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_idle();
      return (m_q.size() == 0) && (cyc >= m_busy_until);
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] addr);
      logic [31:0] r;
      logic [31:0] st;
      st = '0;
      st[9]  = (m_q.size() == DEPTH);
      st[10] = m_idle();
      st[11] = m_ovf;
      r = '0;
      if (addr[2]) r = r | {26'b0, m_leds};
      if (addr[4]) r = r | st;
      return r;
   endfunction

   // Model of one clock edge with the given inputs.
   task automatic model_edge(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit rstn);
      bit full;
      frame_t f;
      if (!rstn) begin
         m_leds = '0;
         m_q.delete();
         m_ovf = 1'b0;
         m_busy_until = 0;
      end else begin
         full = (m_q.size() == DEPTH);
         if (m_q.size() > 0 && cyc >= m_busy_until) begin
            f.data  = m_q.pop_front();
            f.start = cyc;
            exp_q.push_back(f);
            m_busy_until = cyc + FRAME;
         end
         if (wr && addr[3] && !full) m_q.push_back(wdata[7:0]);
         if (wr && addr[2]) m_leds = wdata[5:0];
         m_ovf = (wr && addr[3] && full) || (m_ovf && !(wr && addr[4] && wdata[11]));
      end
   endtask

   task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit rstn);
      rd_t e;
      @(negedge clk);
      io_wr    = wr;
      io_addr  = addr;
      io_wdata = wdata;
      resetn   = rstn;
      e.rdata  = m_rdata(addr);
      e.leds   = m_leds;
      rd_q.push_back(e);
      @(posedge clk);
      cyc++;
      model_edge(wr, addr, wdata, rstn);
   endtask

   function automatic logic [31:0] rand_addr(input logic [2:0] sel);
      logic [31:0] a;
      a = $urandom;
      a[4:2] = sel;
      return a;
   endfunction

   task automatic idle_step();
      step(1'b0, rand_addr(3'($urandom_range(0, 7))), $urandom, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!m_idle() && n < 3000) begin
         idle_step();
         n++;
      end
      if (!m_idle()) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got busy want idle (cycle %0d)", cyc);
      end
      repeat (5) idle_step();
   endtask

   // Read monitor: compares io_rdata/leds against the expectation queued this cycle.
   always begin
      rd_t e;
      @(negedge clk);
      #2;
      if (rd_q.size() > 0) begin
         e = rd_q.pop_front();
         check("io_rdata", io_rdata, e.rdata);
         check("leds", {26'b0, leds}, {26'b0, e.leds});
      end
   end

   // Serial monitor: detects a start bit, samples mid-bit, checks byte and start cycle.
   always begin
      int         start;
      logic [7:0] data;
      bit         aborted;
      frame_t     f;
      @(negedge clk);
      #1;
      if (resetn === 1'b1 && uart_tx === 1'b0) begin
         start   = cyc;
         data    = '0;
         aborted = 1'b0;
         for (int k = 1; k <= 9 * DIV + DIV / 2; k++) begin
            @(negedge clk);
            #1;
            if (resetn !== 1'b1) begin
               aborted = 1'b1;
               break;
            end
            if ((k % DIV) == DIV / 2) begin
               if (k / DIV == 0) check("uart_start_bit", {31'b0, uart_tx}, 32'd0);
               else if (k / DIV == 9) check("uart_stop_bit", {31'b0, uart_tx}, 32'd1);
               else data[k / DIV - 1] = uart_tx;
            end
         end
         if (aborted) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL uart_unexpected_frame: got byte %h want none (cycle %0d)", data, cyc);
         end else begin
            f = exp_q.pop_front();
            check("uart_byte", {24'b0, data}, {24'b0, f.data});
            check("uart_start_cycle", start, f.start);
         end
      end
   end

   initial begin
      int         r;
      int         pd;
      int         n;
      logic [2:0] sel;
      logic [31:0] wd;

      // Reset and idle
      repeat (3) step(1'b0, STAT_ADDR, '0, 1'b0);
      #1 check("uart_tx_after_reset", {31'b0, uart_tx}, 32'd1);
      step(1'b0, STAT_ADDR, '0, 1'b1);
      step(1'b0, LED_ADDR, '0, 1'b1);

      // LED register
      step(1'b1, LED_ADDR, 32'h0000_002A, 1'b1);
      step(1'b0, LED_ADDR, '0, 1'b1);
      step(1'b1, LED_ADDR, 32'h0000_03FF, 1'b1);
      step(1'b0, LED_ADDR, '0, 1'b1);

      // Single frame
      step(1'b1, DATA_ADDR, 32'h0000_0055, 1'b1);
      drain();

      // Burst: fill FIFO, overflow, clear overflow
      for (int i = 0; i < 7; i++) step(1'b1, DATA_ADDR, 32'h41 + i, 1'b1);
      step(1'b0, STAT_ADDR, '0, 1'b1);
      step(1'b1, STAT_ADDR, 32'h0000_0800, 1'b1);
      step(1'b0, STAT_ADDR, '0, 1'b1);
      // Write while full on the very edge that pops: still dropped
      n = 0;
      while (cyc + 1 < m_busy_until && n < 200) begin
         step(1'b0, STAT_ADDR, '0, 1'b1);
         n++;
      end
      step(1'b1, DATA_ADDR, 32'h0000_0050, 1'b1);
      step(1'b0, STAT_ADDR, '0, 1'b1);
      drain();

      // Push and pop on the same edge at count DEPTH-1
      for (int i = 0; i < 4; i++) step(1'b1, DATA_ADDR, 32'h60 + i, 1'b1);
      n = 0;
      while (cyc + 1 < m_busy_until && n < 200) begin
         step(1'b0, STAT_ADDR, '0, 1'b1);
         n++;
      end
      step(1'b1, DATA_ADDR, 32'h0000_0064, 1'b1);
      step(1'b0, STAT_ADDR, '0, 1'b1);
      drain();

      // Randomized traffic with alternating light/heavy data phases
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(0, 99);
         pd = ((i / 200) % 2 == 1) ? 60 : 4;
         wd = $urandom;
         if (r < pd) begin
            sel = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'b010;
            step(1'b1, rand_addr(sel), wd, 1'b1);
         end else if (r < pd + 6) begin
            step(1'b1, rand_addr(3'b001), wd, 1'b1);
         end else if (r < pd + 10) begin
            step(1'b1, rand_addr(3'b100), wd, 1'b1);
         end else begin
            step(1'b0, rand_addr(3'($urandom_range(0, 7))), wd, 1'b1);
         end
      end
      drain();

      // Reset mid-frame with bytes queued
      for (int i = 0; i < 3; i++) step(1'b1, DATA_ADDR, 32'hA0 + i, 1'b1);
      repeat (35) step(1'b0, STAT_ADDR, '0, 1'b1);
      step(1'b0, STAT_ADDR, '0, 1'b0);
      #1 check("uart_tx_mid_frame_reset", {31'b0, uart_tx}, 32'd1);
      repeat (150) idle_step();
      drain();

      check("exp_frames_left", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
